// File: rtl/uart_phy_trx.sv
// uart_phy_trx: byte-level UART transceiver (8N1, or 8E1 when UART_PARITY_EN
// is defined) running entirely on CLK_SYS.
//
// Ports:
//   CLK_SYS   in   system clock
//   RSTN      in   synchronous active-low reset
//   RXD       in   asynchronous serial input, idle high
//   TXD       out  serial output, idle high
//   TX_START  in   one-cycle pulse: send TX_DATA (ignored while TX is busy)
//   TX_DATA   in   byte to send, captured when TX_START is accepted
//   RX_DATA   out  last correctly received byte
//   RX_VALID  out  one-cycle pulse when RX_DATA updates
//   RDY_FLAG  out  high when both TX and RX are idle
//   FRAME_ERR out  one-cycle pulse on bad stop bit (or bad parity)
//
// Optional feature macro: UART_PARITY_EN (even parity bit after the data bits).
`timescale 1ns/1ps
module uart_phy_trx #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115_200,
  parameter int BITWIDTH = 8
) (
  input  logic                CLK_SYS,
  input  logic                RSTN,
  input  logic                RXD,
  output logic                TXD,
  input  logic                TX_START,
  input  logic [BITWIDTH-1:0] TX_DATA,
  output logic [BITWIDTH-1:0] RX_DATA,
  output logic                RX_VALID,
  output logic                RDY_FLAG,
  output logic                FRAME_ERR
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  if (CLKS_PER_BIT < 4) begin : g_bad_baud
    $error("uart_phy_trx: CLK_FREQ/BAUD must be at least 4");
  end
  if (BITWIDTH != 8) begin : g_bad_width
    $error("uart_phy_trx: only BITWIDTH=8 is supported");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_PARITY_EN
    S_PAR,
`endif
    S_STOP
  } st_t;

  // RXD synchronizer plus one more flop for falling-edge detection.
  logic [1:0] sync_q;
  logic       rx_prev_q;
  logic       rx_s;
  assign rx_s = sync_q[1];

  always_ff @(posedge CLK_SYS) begin
    if (!RSTN) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[0], RXD};
      rx_prev_q <= rx_s;
    end
  end

  // ---------------- transmitter ----------------
  st_t                 tx_st_q, tx_st_d;
  logic [CNT_W-1:0]    tx_cnt_q, tx_cnt_d;
  logic [2:0]          tx_bit_q, tx_bit_d;
  logic [BITWIDTH-1:0] tx_byte_q, tx_byte_d;
  logic                txd_q, txd_d;

  // txd_d is the line level belonging to the next state, so TXD is a clean
  // register output that changes on the same edge as the state.
  always_comb begin
    tx_st_d   = tx_st_q;
    tx_cnt_d  = tx_cnt_q + 1'b1;
    tx_bit_d  = tx_bit_q;
    tx_byte_d = tx_byte_q;
    txd_d     = txd_q;
    case (tx_st_q)
      S_IDLE: begin
        tx_cnt_d = '0;
        txd_d    = 1'b1;
        if (TX_START) begin
          tx_byte_d = TX_DATA;
          tx_bit_d  = '0;
          tx_st_d   = S_START;
          txd_d     = 1'b0;
        end
      end
      S_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          tx_st_d  = S_DATA;
          txd_d    = tx_byte_q[0];
        end
      end
      S_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            tx_st_d = S_PAR;
            txd_d   = ^tx_byte_q;
`else
            tx_st_d = S_STOP;
            txd_d   = 1'b1;
`endif
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
            txd_d    = tx_byte_q[tx_bit_q + 3'd1];
          end
        end
      end
`ifdef UART_PARITY_EN
      S_PAR: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          tx_st_d  = S_STOP;
          txd_d    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          tx_st_d  = S_IDLE;
          txd_d    = 1'b1;
        end
      end
      default: begin
        tx_st_d = S_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK_SYS) begin
    if (!RSTN) begin
      tx_st_q  <= S_IDLE;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      txd_q    <= 1'b1;
    end else begin
      tx_st_q  <= tx_st_d;
      tx_cnt_q <= tx_cnt_d;
      tx_bit_q <= tx_bit_d;
      txd_q    <= txd_d;
    end
  end

  always_ff @(posedge CLK_SYS) tx_byte_q <= tx_byte_d;

  // ---------------- receiver ----------------
  st_t                 rx_st_q, rx_st_d;
  logic [CNT_W-1:0]    rx_cnt_q, rx_cnt_d;
  logic [2:0]          rx_bit_q, rx_bit_d;
  logic [BITWIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [BITWIDTH-1:0] rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                ferr_q, ferr_d;
  logic                stop_ok;
`ifdef UART_PARITY_EN
  logic                par_err_q, par_err_d;
  assign stop_ok = rx_s && !par_err_q;
`else
  assign stop_ok = rx_s;
`endif

  always_comb begin
    rx_st_d    = rx_st_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    ferr_d     = 1'b0;
`ifdef UART_PARITY_EN
    par_err_d  = par_err_q;
`endif
    case (rx_st_q)
      S_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_s) rx_st_d = S_START;
      end
      // Half-bit check of the start bit; a high line here was a glitch.
      S_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          rx_st_d  = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s, rx_shift_q[BITWIDTH-1:1]};
          if (rx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            rx_st_d = S_PAR;
`else
            rx_st_d = S_STOP;
`endif
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end
      end
`ifdef UART_PARITY_EN
      S_PAR: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d  = '0;
          par_err_d = rx_s ^ (^rx_shift_q);
          rx_st_d   = S_STOP;
        end
      end
`endif
      // Leaving at mid-stop lets the next start edge be hunted half a bit
      // early, which absorbs transmitter baud drift.
      S_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          rx_st_d  = S_IDLE;
          if (stop_ok) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: rx_st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_SYS) begin
    if (!RSTN) begin
      rx_st_q    <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      ferr_q     <= 1'b0;
`ifdef UART_PARITY_EN
      par_err_q  <= 1'b0;
`endif
    end else begin
      rx_st_q    <= rx_st_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      ferr_q     <= ferr_d;
`ifdef UART_PARITY_EN
      par_err_q  <= par_err_d;
`endif
    end
  end

  always_ff @(posedge CLK_SYS) rx_shift_q <= rx_shift_d;

  // Ready reflects the busy state both directions are entering.
  logic rdy_q;
  always_ff @(posedge CLK_SYS) begin
    if (!RSTN) rdy_q <= 1'b1;
    else       rdy_q <= !((tx_st_d != S_IDLE) || (rx_st_d != S_IDLE));
  end

  assign TXD       = txd_q;
  assign RX_DATA   = rx_data_q;
  assign RX_VALID  = rx_valid_q;
  assign RDY_FLAG  = rdy_q;
  assign FRAME_ERR = ferr_q;

endmodule
